pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder_pkg.sv | 15 +
 rtl/adder_defs.vh | 16 +
 rtl/adder_seg.sv | 25 ++
 rtl/pipelined_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_adder.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Package: opcode encodings, default geometry and segment sizing helper.
package pipelined_adder_pkg;
`include "adder_defs.vh"

    localparam logic OP_ADD = `ADDER_OP_ADD;
    localparam logic OP_SUB = `ADDER_OP_SUB;

    localparam int ADDER_DEF_WIDTH  = `ADDER_DEFAULT_WIDTH;
    localparam int ADDER_DEF_STAGES = `ADDER_DEFAULT_STAGES;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_defs.vh
// Shared constants and elaboration checks for the pipelined adder family.
`ifndef ADDER_DEFS_VH
`define ADDER_DEFS_VH

`define ADDER_OP_ADD         1'b0
`define ADDER_OP_SUB         1'b1
`define ADDER_DEFAULT_WIDTH  8
`define ADDER_DEFAULT_STAGES 2

// Expands to a generate-if; place it directly in a module body.
`define ADDER_CHECK_DIV(W, S) \
    if (((S) < 1) || (((W) % (S)) != 0)) begin : g_bad_div \
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES"); \
    end

`endif

// File: rtl/adder_seg.sv
// SEG-bit ripple-carry adder segment built from full-adder cells.
// Latency: combinational. Backpressure: none (pure datapath).
// Carry-in enters bit 0; carry-out leaves the top cell.
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, carry chain split into STAGES segments.
// Latency: STAGES cycles accept-to-valid, 1 beat/cycle; optional ovf under PIPELINED_ADDER_OVF_EN.
// Backpressure: out_valid && !out_ready freezes the whole pipe; in_ready = !stall, no skid.
`include "adder_defs.vh"

module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_DEF_WIDTH,
    parameter int STAGES = ADDER_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    `ADDER_CHECK_DIV(WIDTH, STAGES)

    logic             stall;
    logic             adv;
    logic [WIDTH-1:0] b_eff;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall;
    assign b_eff    = (op == OP_SUB) ? ~b : b;

    // d_q carries finished sum segments below k and untouched A segments
    // above; the skew register holds only the B' segments still to be added.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BW_IN = WIDTH - k * SEG;

        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] d_in;
        logic [BW_IN-1:0] bx_in;
        logic [SEG-1:0]   seg_s;
        logic             seg_co;
        logic [WIDTH-1:0] d_nxt;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] d_q;

        if (k == 0) begin : g_src
            assign v_in  = in_valid;
            assign c_in  = ci;
            assign d_in  = a;
            assign bx_in = b_eff;
        end else begin : g_src
            assign v_in  = g_stage[k-1].v_q;
            assign c_in  = g_stage[k-1].c_q;
            assign d_in  = g_stage[k-1].d_q;
            assign bx_in = g_stage[k-1].g_skew.bx_q;
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (d_in[k*SEG +: SEG]),
            .b    (bx_in[SEG-1:0]),
            .cin  (c_in),
            .s    (seg_s),
            .cout (seg_co)
        );

        always_comb begin
            d_nxt                = d_in;
            d_nxt[k*SEG +: SEG]  = seg_s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                d_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= seg_co;
                d_q <= d_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [BW_IN-SEG-1:0] bx_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bx_q <= '0;
                end else if (adv) begin
                    bx_q <= bx_in[BW_IN-1:SEG];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic c_msb;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign c_msb = d_in[WIDTH-1] ^ bx_in[SEG-1] ^ seg_s[SEG-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ seg_co;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign s         = g_stage[STAGES-1].d_q;
    assign co        = g_stage[STAGES-1].c_q;
`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: WIDTH=8/STAGES=2 main instance plus STAGES 1/4/8 sweep instances.
module tb_pipelined_adder;

    localparam int STAGES = 2;
    localparam int NSW    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, ci, op, out_ready, sw_valid;
    logic [7:0] a, b;
    logic       in_ready, out_valid, co;
    logic [7:0] s;
    logic [NSW-1:0] sw_ir, sw_ov, sw_co;
    logic [7:0]     sw_s [NSW];
`ifdef PIPELINED_ADDER_OVF_EN
    logic           ovf;
    logic [NSW-1:0] sw_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int stg [NSW] = '{1, 4, 8};

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .s(s), .co(co)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[0]),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(sw_ov[0]), .out_ready(out_ready),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(sw_ovf[0]),
`endif
        .s(sw_s[0]), .co(sw_co[0])
    );

    pipelined_adder #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[1]),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(sw_ov[1]), .out_ready(out_ready),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(sw_ovf[1]),
`endif
        .s(sw_s[1]), .co(sw_co[1])
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_ir[2]),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(sw_ov[2]), .out_ready(out_ready),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(sw_ovf[2]),
`endif
        .s(sw_s[2]), .co(sw_co[2])
    );

    // Reference: plain integer arithmetic on the operands, signed range for overflow.
    function automatic exp_t model(input logic [7:0] a_, input logic [7:0] b_,
                                   input logic ci_, input logic op_, input int cyc_);
        exp_t e;
        int   bb, tot, sa, sbv, stot;
        bb   = op_ ? (255 - int'(b_)) : int'(b_);
        tot  = int'(a_) + bb + int'(ci_);
        sa   = int'($signed(a_));
        sbv  = op_ ? (-int'($signed(b_)) - 1) : int'($signed(b_));
        stot = sa + sbv + int'(ci_);
        e.s   = 8'(tot % 256);
        e.co  = (tot >= 256);
        e.ovf = (stot > 127) || (stot < -128);
        e.cyc = cyc_;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        a  = 8'($urandom);
        b  = 8'($urandom);
        ci = 1'($urandom);
        op = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (s !== 8'd0) begin failures++; $display("FAIL reset_s got=%0d exp=0", s); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", co); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'd244, 8'd64,  8'd64,  8'd144, 8'd255, 8'd0};
        logic [7:0] tb_ [6] = '{8'd232, 8'd144, 8'd144, 8'd64,  8'd255, 8'd0};
        logic       tci [6] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b0};
        logic       top [6] = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
        logic [7:0] ts  [6] = '{8'd221, 8'd208, 8'd176, 8'd80,  8'd255, 8'd0};
        logic       tco [6] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb_[i]; ci = tci[i]; op = top[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int n = 1; n <= STAGES + 1; n++) begin
                checks++;
                if (out_valid !== (n == STAGES)) begin
                    failures++;
                    $display("FAIL dir%0d_valid_n%0d got=%b exp=%b", i, n, out_valid, (n == STAGES));
                end
                if (n == STAGES) begin
                    checks++; if (s !== ts[i]) begin failures++; $display("FAIL dir%0d_s got=%0d exp=%0d", i, s, ts[i]); end
                    checks++; if (co !== tco[i]) begin failures++; $display("FAIL dir%0d_co got=%b exp=%b", i, co, tco[i]); end
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        int   sent = 0, got = 0, cyc = 0;
        logic fire;
        exp_t e;
        sb.delete();
        out_ready = 1'b1;
        rand_beat();
        in_valid = 1'b1;
        while (got < 16 && cyc < 300) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (fire) begin sb.push_back(model(a, b, ci, op, cyc)); sent++; end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL b2b_extra_result got=%0d exp=none", s);
                end else begin
                    e = sb.pop_front();
                    checks++; if (s !== e.s) begin failures++; $display("FAIL b2b_s beat%0d got=%0d exp=%0d", got, s, e.s); end
                    checks++; if (co !== e.co) begin failures++; $display("FAIL b2b_co beat%0d got=%b exp=%b", got, co, e.co); end
                    checks++; if (cyc - e.cyc != STAGES) begin failures++; $display("FAIL b2b_latency beat%0d got=%0d exp=%0d", got, cyc - e.cyc, STAGES); end
`ifdef PIPELINED_ADDER_OVF_EN
                    checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL b2b_ovf beat%0d got=%b exp=%b", got, ovf, e.ovf); end
`endif
                end
                got++;
            end
            tick();
            if (fire) begin
                if (sent < 16) rand_beat();
                else in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", got); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_stall();
        int         sent = 0, got = 0, cyc = 0;
        logic       fire, prev_stall;
        logic [7:0] p_s;
        logic       p_co, p_ov;
        exp_t       e;
        sb.delete();
        prev_stall = 1'b0;
        p_s = '0; p_co = 1'b0; p_ov = 1'b0;
        rand_beat();
        in_valid = 1'b1;
        while (got < 16 && cyc < 300) begin
            out_ready = !((cyc >= 6) && (cyc < 11));
            @(negedge clk);
            if (!out_ready && out_valid) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc%0d got=%b exp=0", cyc, in_ready); end
            end
            if (prev_stall) begin
                checks++;
                if (s !== p_s || co !== p_co || out_valid !== p_ov) begin
                    failures++;
                    $display("FAIL stall_hold cyc%0d got=%0d/%b/%b exp=%0d/%b/%b", cyc, s, co, out_valid, p_s, p_co, p_ov);
                end
            end
            prev_stall = out_valid && !out_ready;
            p_s = s; p_co = co; p_ov = out_valid;
            fire = in_valid && in_ready;
            if (fire) begin sb.push_back(model(a, b, ci, op, cyc)); sent++; end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL stall_extra_result got=%0d exp=none", s);
                end else begin
                    e = sb.pop_front();
                    checks++; if (s !== e.s) begin failures++; $display("FAIL stall_s beat%0d got=%0d exp=%0d", got, s, e.s); end
                    checks++; if (co !== e.co) begin failures++; $display("FAIL stall_co beat%0d got=%b exp=%b", got, co, e.co); end
                end
                got++;
            end
            tick();
            if (fire) begin
                if (sent < 16) rand_beat();
                else in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (got != 16) begin failures++; $display("FAIL stall_count got=%0d exp=16", got); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reset_in_flight();
        out_ready = 1'b0;
        a = 8'd10; b = 8'd20; ci = 1'b0; op = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'd200; b = 8'd100; ci = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rif_pre_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_out_valid got=%b exp=0", out_valid); end
        checks++; if (s !== 8'd0) begin failures++; $display("FAIL rif_s got=%0d exp=0", s); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL rif_co got=%b exp=0", co); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rif_in_ready got=%b exp=1", in_ready); end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_stale n%0d got=%b exp=0", n, out_valid); end
        end
    endtask

    task automatic test_stage_sweep();
        out_ready = 1'b1;
        a = 8'd255; b = 8'd255; ci = 1'b1; op = 1'b0;
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            for (int i = 0; i < NSW; i++) begin
                if (n == 1) begin
                    checks++; if (sw_ir[i] !== 1'b1) begin failures++; $display("FAIL sweep%0d_in_ready got=%b exp=1", stg[i], sw_ir[i]); end
                end
                checks++;
                if (sw_ov[i] !== (n == stg[i])) begin
                    failures++; $display("FAIL sweep%0d_valid_n%0d got=%b exp=%b", stg[i], n, sw_ov[i], (n == stg[i]));
                end
                if (n == stg[i]) begin
                    checks++; if (sw_s[i] !== 8'd255) begin failures++; $display("FAIL sweep%0d_s got=%0d exp=255", stg[i], sw_s[i]); end
                    checks++; if (sw_co[i] !== 1'b1) begin failures++; $display("FAIL sweep%0d_co got=%b exp=1", stg[i], sw_co[i]); end
`ifdef PIPELINED_ADDER_OVF_EN
                    checks++; if (sw_ovf[i] !== 1'b0) begin failures++; $display("FAIL sweep%0d_ovf got=%b exp=0", stg[i], sw_ovf[i]); end
`endif
                end
            end
            tick();
        end
    endtask

`ifdef PIPELINED_ADDER_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta [2] = '{8'd127, 8'd128};
        logic [7:0] tb_ [2] = '{8'd1,   8'd1};
        logic       tci [2] = '{1'b0,   1'b1};
        logic       top [2] = '{1'b0,   1'b1};
        logic [7:0] ts  [2] = '{8'd128, 8'd127};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = ta[i]; b = tb_[i]; ci = tci[i]; op = top[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int n = 1; n < STAGES; n++) tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf%0d_valid got=%b exp=1", i, out_valid); end
            checks++; if (s !== ts[i]) begin failures++; $display("FAIL ovf%0d_s got=%0d exp=%0d", i, s, ts[i]); end
            checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf%0d_ovf got=%b exp=1", i, ovf); end
            tick();
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; op = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        test_stage_sweep();
`ifdef PIPELINED_ADDER_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
